// File: rtl/dec_sel_sequencer.sv
// Scan sequencer for a downstream 2-to-4 decoder: steps the select code
// up or down with a programmable dwell, in single-pass or continuous mode.
module dec_sel_sequencer #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               dir,
    input  logic               cont,
    input  logic [DWELL_W-1:0] dwell,
    output logic [1:0]         w,
    output logic               en,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_n;

    logic [1:0]         w_n;
    logic               en_n;
    logic               busy_n;
    logic               done_n;
    logic [DWELL_W-1:0] cnt, cnt_n;
    logic [DWELL_W-1:0] dwell_q, dwell_n;
    logic               dir_q, dir_n;
    logic               cont_q, cont_n;

    logic [1:0] final_code;
    logic [1:0] step_code;

    assign final_code = dir_q ? 2'b00 : 2'b11;
    // Mod-4 step doubles as the wrap in continuous mode.
    assign step_code  = dir_q ? w - 2'd1 : w + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            w       <= 2'b00;
            en      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            dwell_q <= '0;
            dir_q   <= 1'b0;
            cont_q  <= 1'b0;
        end else begin
            state   <= state_n;
            w       <= w_n;
            en      <= en_n;
            busy    <= busy_n;
            done    <= done_n;
            cnt     <= cnt_n;
            dwell_q <= dwell_n;
            dir_q   <= dir_n;
            cont_q  <= cont_n;
        end
    end

    always_comb begin
        state_n = state;
        w_n     = w;
        en_n    = en;
        busy_n  = busy;
        done_n  = 1'b0;
        cnt_n   = cnt;
        dwell_n = dwell_q;
        dir_n   = dir_q;
        cont_n  = cont_q;

        unique case (state)
            IDLE: begin
                en_n   = 1'b0;
                busy_n = 1'b0;
                if (start && !stop) begin
                    state_n = RUN;
                    dir_n   = dir;
                    cont_n  = cont;
                    dwell_n = dwell;
                    w_n     = dir ? 2'b11 : 2'b00;
                    en_n    = 1'b1;
                    busy_n  = 1'b1;
                    cnt_n   = dwell;
                end
            end
            RUN: begin
                if (stop) begin
                    state_n = IDLE;
                    en_n    = 1'b0;
                    busy_n  = 1'b0;
                end else if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (w != final_code || cont_q) begin
                    w_n   = step_code;
                    cnt_n = dwell_q;
                end else begin
                    state_n = DONE;
                    done_n  = 1'b1;
                    en_n    = 1'b0;
                    busy_n  = 1'b0;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dec_sel_sequencer.sv
// Directed bench for dec_sel_sequencer: cycle-index scan model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_dec_sel_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       dir = 1'b0;
    logic       cont = 1'b0;
    logic [3:0] dwell = 4'd0;
    logic [1:0] w;
    logic       en;
    logic       busy;
    logic       done;

    dec_sel_sequencer #(.DWELL_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .dir   (dir),
        .cont  (cont),
        .dwell (dwell),
        .w     (w),
        .en    (en),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit mon    = 1'b0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Scan model: outputs follow from the cycle index t since start.
    bit         m_act  = 0;
    bit         m_dn   = 0;
    int         m_t    = 0;
    bit         m_dir  = 0;
    bit         m_cont = 0;
    int         m_dw   = 0;
    logic [1:0] m_w    = 2'd0;
    logic       m_en   = 1'b0;
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;

    function automatic logic [1:0] code_at(int tt);
        int idx;
        idx = (tt / (m_dw + 1)) % 4;
        return m_dir ? 2'(3 - idx) : 2'(idx);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_act = 0; m_dn = 0; m_w = 2'd0;
            m_en = 0; m_busy = 0; m_done = 0;
        end else if (m_act) begin
            if (stop) begin
                m_act = 0; m_en = 0; m_busy = 0;
            end else begin
                m_t++;
                if (!m_cont && m_t == 4 * (m_dw + 1)) begin
                    m_act = 0; m_dn = 1; m_done = 1;
                    m_en = 0; m_busy = 0;
                end else begin
                    m_w = code_at(m_t);
                end
            end
        end else if (m_dn) begin
            m_dn = 0; m_done = 0;
        end else if (start && !stop) begin
            m_act = 1; m_t = 0;
            m_dir = dir; m_cont = cont; m_dw = int'(dwell);
            m_w = code_at(0); m_en = 1; m_busy = 1;
        end
    end

    always @(negedge clk) begin
        if (mon) begin
            chk("model_w", 32'(w), 32'(m_w));
            chk("model_en", 32'(en), 32'(m_en));
            chk("model_busy", 32'(busy), 32'(m_busy));
            chk("model_done", 32'(done), 32'(m_done));
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic go(bit d, bit c, logic [3:0] dw);
        dir = d; cont = c; dwell = dw; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(string nm);
        int k = 0;
        while (done !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk(nm, 32'(done), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        cyc(2);
        chk("rst_w", 32'(w), 32'd0);
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        mon = 1'b1;
        cyc(1);

        // Up scan, dwell 0
        go(0, 0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            chk("up_w", 32'(w), 32'(i));
            chk("up_en", 32'(en), 32'd1);
            @(negedge clk);
        end
        chk("up_done", 32'(done), 32'd1);
        chk("up_done_en", 32'(en), 32'd0);
        chk("up_done_w", 32'(w), 32'd3);
        @(negedge clk);
        chk("up_idle_done", 32'(done), 32'd0);
        chk("up_idle_busy", 32'(busy), 32'd0);
        chk("up_idle_w", 32'(w), 32'd3);

        // Down scan, dwell 2; start during DONE is ignored
        go(1, 0, 4'd2);
        for (int i = 0; i < 12; i++) begin
            chk("dn_w", 32'(w), 32'(3 - i / 3));
            chk("dn_en", 32'(en), 32'd1);
            @(negedge clk);
        end
        chk("dn_done", 32'(done), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("dn_start_in_done", 32'(busy), 32'd0);
        cyc(1);

        // Continuous, dwell 1, stop at second 01 cycle
        go(0, 1, 4'd1);
        chk("ct_c0", 32'(w), 32'd0);
        cyc(3);
        chk("ct_c3", 32'(w), 32'd1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_en", 32'(en), 32'd0);
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_done", 32'(done), 32'd0);
        chk("stop_w", 32'(w), 32'd1);
        cyc(1);

        // Continuous wrap, dwell 0
        go(0, 1, 4'd0);
        cyc(4);
        chk("wrap_w", 32'(w), 32'd0);
        chk("wrap_busy", 32'(busy), 32'd1);
        chk("wrap_nodone", 32'(done), 32'd0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        cyc(1);

        // start+stop together in IDLE
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("prio_busy", 32'(busy), 32'd0);
        chk("prio_en", 32'(en), 32'd0);

        // start mid-RUN ignored
        go(0, 0, 4'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("ign_w2", 32'(w), 32'd2);
        @(negedge clk);
        chk("ign_w3", 32'(w), 32'd3);
        wait_done("ign_done");

        // Reset mid-scan at w=10, then immediate restart
        go(0, 0, 4'd0);
        cyc(2);
        chk("rm_pre_w", 32'(w), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        chk("rm_w", 32'(w), 32'd0);
        chk("rm_en", 32'(en), 32'd0);
        chk("rm_busy", 32'(busy), 32'd0);
        chk("rm_done", 32'(done), 32'd0);
        rst = 1'b0;
        go(1, 0, 4'd0);
        chk("rm_restart_w", 32'(w), 32'd3);
        chk("rm_restart_en", 32'(en), 32'd1);
        wait_done("rm_done_seen");

        // Latched settings survive input changes during RUN
        go(0, 0, 4'd1);
        dir = 1'b1; dwell = 4'd3; cont = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("latch_w", 32'(w), 32'(i / 2));
            @(negedge clk);
        end
        chk("latch_done", 32'(done), 32'd1);
        cyc(1);

        // Maximum dwell: 16 cycles per code
        begin
            int n;
            go(0, 0, 4'd15);
            n = 0;
            while (en === 1'b1 && n < 100) begin
                n++;
                @(negedge clk);
            end
            chk("maxdw_en_cycles", 32'(n), 32'd64);
            chk("maxdw_done", 32'(done), 32'd1);
        end
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dec_sel_sequencer.md
DEC_SEL_SEQUENCER -- requirements
Module: dec_sel_sequencer

Interface
REQ-001 The block SHALL have parameter DWELL_W, default 4, giving the width of the dwell count.
REQ-002 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1, reset (synchronous, active-high).
REQ-004 The block SHALL have port start, input, 1, single-cycle request to begin a scan.
REQ-005 The block SHALL have port stop, input, 1, abort request.
REQ-006 The block SHALL have port dir, input, 1, scan direction: 0 = up (00->11), 1 = down (11->00).
REQ-007 The block SHALL have port cont, input, 1, scan mode: 0 = single pass, 1 = continuous wrap.
REQ-008 The block SHALL have port dwell, input, DWELL_W, extra cycles each code is held.
REQ-009 The block SHALL have port w, output, 2, select code to the downstream 2-to-4 decoder.
REQ-010 The block SHALL have port en, output, 1, enable to the downstream 2-to-4 decoder.
REQ-011 The block SHALL have port busy, output, 1, high while in RUN.
REQ-012 The block SHALL have port done, output, 1, one-cycle pulse at the end of a single pass.
REQ-013 The block SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 In IDLE: en=0, busy=0, done=0, and w holds its last value.
REQ-017 IDLE with start=1 and stop=0 SHALL enter RUN on the next edge, with the following actions.
- dir, cont and dwell are latched into internal registers.
- w is set to 2'b00 if dir=0, else 2'b11.
- en=1, busy=1.
- The dwell counter is loaded with the latched dwell value.
REQ-018 IDLE with start=1 and stop=1 SHALL remain in IDLE, because stop has priority.
REQ-019 In RUN, each code SHALL be held for latched dwell+1 cycles; dwell=0 gives one cycle per code.
REQ-020 In RUN, the dwell counter SHALL decrement each cycle while nonzero.
REQ-021 When the dwell counter is zero and the current code is not the pass-final code, w SHALL advance by ±1 (mod 4) and the counter SHALL reload.
REQ-022 The pass-final code SHALL be 2'b11 for up and 2'b00 for down.
REQ-023 When the dwell counter is zero at the pass-final code with cont=0, the FSM SHALL go to DONE, with done=1, en=0, busy=0, and w held.
REQ-024 When the dwell counter is zero at the pass-final code with cont=1, w SHALL wrap (11->00 up, 00->11 down), the counter SHALL reload, and the FSM SHALL stay in RUN.
REQ-025 DONE SHALL last exactly one cycle, then return to IDLE with done=0.
REQ-026 stop=1 in RUN SHALL cause IDLE on the next edge, with en=0, busy=0, done=0, and w frozen; stop overrides the dwell and advance logic.
REQ-027 start in RUN or DONE SHALL be ignored, with no restart and no re-latch.
REQ-028 Changes on dir, cont or dwell during RUN SHALL have no effect until the next accepted start.
REQ-029 The dwell counter SHALL be DWELL_W bits wide, with no overflow; the maximum hold per code is 2^DWELL_W cycles.
REQ-030 en SHALL be 1 for exactly 4*(dwell+1) consecutive cycles in an unaborted single pass.

Reset
REQ-031 rst=1 at a clock edge SHALL force the following, in any state including mid-RUN: IDLE, w=2'b00, en=0, busy=0, done=0, dwell counter=0, and latched dir/cont/dwell=0.
REQ-032 rst SHALL have priority over start and stop.
REQ-033 The first start SHALL be accepted on the first edge after rst deasserts.

Verification
REQ-034 Up scan: start with dir=0, cont=0, dwell=0 -> w=00,01,10,11 on 4 consecutive cycles with en=1, then done=1 for 1 cycle with en=0, then IDLE.
REQ-035 Down scan with dwell: start with dir=1, cont=0, dwell=2 -> w=11×3, 10×3, 01×3, 00×3 cycles (12 cycles en=1), then a done pulse.
REQ-036 Continuous scan and stop: start with dir=0, cont=1, dwell=1 -> sequence 00,00,01,01,10,10,11,11,00,00,... with no done; stop at the second 01 cycle -> next cycle en=0, busy=0, done=0, w=01.
REQ-037 Priority and ignore: start=1 and stop=1 together in IDLE -> stays IDLE (busy=0); start pulsed mid-RUN -> sequence unchanged.
REQ-038 Reset mid-scan: rst during RUN at w=10 -> next cycle w=00, en=0, busy=0, done=0; start on the cycle after rst drops -> a normal scan begins.
REQ-039 Latch check: toggling dir and dwell during RUN -> the scan still follows the values latched at start.
